alu_shift_sequencer: RTL
========================

// Module: alu_shift_sequencer
// PURPOSE
//  Multicycle shift execution unit feeding the ALU result path. Accepts one
//  shift request (operand, 5-bit amount, op select) via valid/ready, applies
//  the 1/2/4/8/16 binary shift stages one per clock, and presents the result
//  via valid/ready. Trades barrel-shifter area for fixed 5-cycle latency.
// PARAMETERS
//  DATA_WIDTH   32  operand/result width; must be 2**SHAMT_WIDTH
//  SHAMT_WIDTH  5   shift-amount width = number of shift stages
// PORTS
//  clock          in   1   single clock; all state on rising edge
//  reset          in   1   synchronous, active-high
//  in_valid       in   1   request present
//  in_ready       out  1   unit can accept request (IDLE only)
//  ctrl_shift_op  in   1   0 = logical left (SLL), 1 = arithmetic right (SRA)
//  ctrl_shiftamt  in   5   shift amount 0..31
//  data_in        in   32  operand
//  out_valid      out  1   result present
//  out_ready      in   1   consumer takes result
//  data_out       out  32  result (registered)
//  busy           out  1   high in SHIFT or DONE
// BEHAVIOUR
//  - Reset (sync, high at edge): state=IDLE, stage=0, data_out=0,
//    out_valid=0, busy=0, in_ready=1 in the cycle after reset deasserts.
//    Reset mid-operation discards the request; no result is produced.
//  - States: IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE: in_ready=1. On edge with in_valid=1: latch data_in to work reg,
//    latch op and amt, stage=0, go SHIFT. Inputs ignored otherwise.
//  - SHIFT: in_ready=0. Each edge: if amt[stage]=1, work reg shifted by
//    2**stage (SLL: zero fill from LSB; SRA: fill with latched operand
//    bit 31, i.e. the sign at accept time); else unchanged. stage+1.
//    At edge with stage=4: data_out<=final value, go DONE.
//  - Latency: accept edge E0; stages apply at E1..E5; out_valid=1 after E5.
//    Fixed; amt=0 takes full latency and returns operand unchanged.
//  - DONE: out_valid=1, data_out stable while out_ready=0 (backpressure
//    held indefinitely). On edge with out_ready=1: out_valid=0, go IDLE.
//    in_ready=0 in DONE; next accept is earliest the edge after the drain
//    edge (throughput one op per 7 cycles min).
//  - in_valid asserted in SHIFT/DONE has no effect; requester must hold
//    it until in_ready.
//  - data_out holds last result in IDLE until overwritten at next E5.
//  - ctrl/data inputs changing after E0 do not affect the in-flight op.
//  - No X propagation: all regs reset; stage counter never exceeds 4.
// TESTING
//  1 SRA 0x80000000 amt 31 -> out_valid 5 cycles after accept,
//    data_out 0xFFFFFFFF
//  2 SLL 0x00000001 amt 31 -> 0x80000000; SLL 0xDEADBEEF amt 4 -> 0xEADBEEF0
//  3 SRA 0x7FFFFFF0 amt 4 -> 0x07FFFFFF; SRA 0xF0000000 amt 0 -> 0xF0000000,
//    still 5-cycle latency
//  4 out_ready low 10 cycles after out_valid -> data_out/out_valid stable,
//    in_ready=0; raise out_ready -> IDLE next cycle, in_ready=1
//  5 reset pulse on 3rd SHIFT cycle -> out_valid never rises, data_out=0,
//    in_ready=1; new request after reset gives correct result
//  6 in_valid toggled with new data during SHIFT -> ignored; result matches
//    original latched operand; random 1000-op compare vs >>> / << model

Source files
------------

// File: rtl/alu_shift_sequencer_if.sv
// ----------------------------------------------------------------------------
// alu_shift_sequencer_if
// Request/result bundle for the multicycle shift unit.
//   master : requester/consumer side (drives request and out_ready)
//   slave  : shift unit side (drives in_ready, result and busy)
// Signals:
//   in_valid, in_ready             request handshake
//   ctrl_shift_op                  0 = SLL, 1 = SRA
//   ctrl_shiftamt [SHAMT_WIDTH]    shift amount
//   data_in  [DATA_WIDTH]          operand
//   out_valid, out_ready           result handshake
//   data_out [DATA_WIDTH]          registered result
//   busy                           unit is working or holding a result
// ----------------------------------------------------------------------------
interface alu_shift_sequencer_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   ctrl_shift_op;
    logic [SHAMT_WIDTH-1:0] ctrl_shiftamt;
    logic [DATA_WIDTH-1:0]  data_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  data_out;
    logic                   busy;

    modport master (
        output in_valid, ctrl_shift_op, ctrl_shiftamt, data_in, out_ready,
        input  in_ready, out_valid, data_out, busy
    );

    modport slave (
        input  in_valid, ctrl_shift_op, ctrl_shiftamt, data_in, out_ready,
        output in_ready, out_valid, data_out, busy
    );
endinterface

// File: rtl/alu_shift_sequencer.sv
// ----------------------------------------------------------------------------
// alu_shift_sequencer
// Multicycle shifter: one request is accepted in IDLE, the 1/2/4/.../2**(N-1)
// shift stages are applied one per clock, and the result is held in DONE
// until the consumer takes it. Latency from accept to out_valid is fixed at
// SHAMT_WIDTH clocks regardless of the shift amount.
// Ports:
//   clock  : single clock, all state on the rising edge
//   reset  : synchronous, active-high
//   bus    : alu_shift_sequencer_if.slave (request, result, busy)
// DATA_WIDTH must equal 2**SHAMT_WIDTH.
// ----------------------------------------------------------------------------
module alu_shift_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    alu_shift_sequencer_if.slave  bus
);
    localparam int STG_W = (SHAMT_WIDTH > 1) ? $clog2(SHAMT_WIDTH) : 1;
    localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(SHAMT_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [STG_W-1:0]       r_stage;
    logic [DATA_WIDTH-1:0]  r_work;
    logic [SHAMT_WIDTH-1:0] r_amt;
    logic                   r_op;
    logic                   r_sign;
    logic [DATA_WIDTH-1:0]  r_data_out;
    logic                   r_out_valid;
    logic                   r_in_ready;
    logic                   r_busy;

    logic [DATA_WIDTH-1:0]  w_cand [SHAMT_WIDTH];
    logic [DATA_WIDTH-1:0]  w_next_work;

    // One candidate per stage: the work register shifted by that stage's
    // fixed power-of-two distance. SRA fills with the sign captured at
    // accept time rather than the current MSB of the work register.
    genvar gi;
    generate
        for (gi = 0; gi < SHAMT_WIDTH; gi++) begin : g_stage
            localparam int SH = 2 ** gi;
            assign w_cand[gi] = r_op
                ? {{SH{r_sign}}, r_work[DATA_WIDTH-1:SH]}
                : {r_work[DATA_WIDTH-1-SH:0], {SH{1'b0}}};
        end
    endgenerate

    assign w_next_work = r_amt[r_stage] ? w_cand[r_stage] : r_work;

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.data_out  = r_data_out;
    assign bus.busy      = r_busy;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_stage     <= '0;
            r_work      <= '0;
            r_amt       <= '0;
            r_op        <= 1'b0;
            r_sign      <= 1'b0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_work     <= bus.data_in;
                        r_amt      <= bus.ctrl_shiftamt;
                        r_op       <= bus.ctrl_shift_op;
                        r_sign     <= bus.data_in[DATA_WIDTH-1];
                        r_stage    <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_work <= w_next_work;
                    if (r_stage == LAST_STAGE) begin
                        r_data_out  <= w_next_work;
                        r_out_valid <= 1'b1;
                        r_stage     <= '0;  // keep the counter within range
                        r_state     <= ST_DONE;
                    end else begin
                        r_stage <= r_stage + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule
